// File: rtl/fifo.sv
// Byte FIFO, 8 deep, with a nibble-serial write side: nibbles are paired
// low-then-high into bytes. Data_Out is registered and changes only on accepted reads.
module fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Data_In,
  output logic [7:0] Data_Out,
  output logic       input_valid,
  output logic       output_valid,
  input  logic       input_enable,
  input  logic       output_enable
);

  typedef enum logic {PH_LO = 1'b0, PH_HI = 1'b1} phase_t;

  phase_t     r_phase;
  phase_t     w_phase_nxt;
  logic [7:0] r_mem [8];
  logic [2:0] r_wr_ptr;
  logic [2:0] r_rd_ptr;
  logic [3:0] r_count;
  logic [3:0] w_count_nxt;
  logic [3:0] r_hold;
  logic       w_wr;
  logic       w_rd;
  logic       w_byte;

  // A pending low nibble is not stored data, so both flags decode count only.
  assign input_valid  = (r_count != 4'd8);
  assign output_valid = (r_count != 4'd0);

  assign w_wr   = input_enable  & input_valid;
  assign w_rd   = output_enable & output_valid;
  assign w_byte = w_wr & (r_phase == PH_HI);

  always_comb begin
    w_phase_nxt = r_phase;
    w_count_nxt = r_count;
    if (w_wr) begin
      w_phase_nxt = (r_phase == PH_LO) ? PH_HI : PH_LO;
    end
    case ({w_byte, w_rd})
      2'b10:   w_count_nxt = r_count + 4'd1;
      2'b01:   w_count_nxt = r_count - 4'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= PH_LO;
      r_count  <= '0;
      r_hold   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_mem    <= '{default: '0};
      Data_Out <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_count <= w_count_nxt;
      if (w_wr && (r_phase == PH_LO)) begin
        r_hold <= Data_In;
      end
      // Write and read slots never collide: a write at full and a read at empty are both refused.
      if (w_byte) begin
        r_mem[r_wr_ptr] <= {Data_In, r_hold};
        r_wr_ptr        <= r_wr_ptr + 3'd1;
      end
      if (w_rd) begin
        Data_Out <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed and random checks for the nibble-in/byte-out FIFO against a
// reference byte queue with its own nibble-pairing state.
module tb_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] Data_In = '0;
  logic [7:0] Data_Out;
  logic       input_valid;
  logic       output_valid;
  logic       input_enable = 1'b0;
  logic       output_enable = 1'b0;

  int n_err = 0;
  int n_chk = 0;

  logic [7:0] m_q [$];
  logic       m_phase = 1'b0;
  logic [3:0] m_hold  = '0;
  logic [7:0] m_dout  = '0;

  fifo u_dut (
    .clk          (clk),
    .rst          (rst),
    .Data_In      (Data_In),
    .Data_Out     (Data_Out),
    .input_valid  (input_valid),
    .output_valid (output_valid),
    .input_enable (input_enable),
    .output_enable(output_enable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = 1'b0;
    m_hold  = '0;
    m_dout  = '0;
  endtask

  // One clock: drive, advance past the edge, update the model, compare.
  task automatic step(input logic ie, input logic oe, input logic [3:0] din);
    logic wr_ok;
    logic rd_ok;
    input_enable  = ie;
    output_enable = oe;
    Data_In       = din;
    wr_ok = ie && (m_q.size() != 8);
    rd_ok = oe && (m_q.size() != 0);
    @(posedge clk);
    #1;
    if (rd_ok) m_dout = m_q.pop_front();
    if (wr_ok) begin
      if (m_phase) m_q.push_back({din, m_hold});
      else         m_hold = din;
      m_phase = ~m_phase;
    end
    input_enable  = 1'b0;
    output_enable = 1'b0;
    check("dout",      Data_Out,              m_dout);
    check("in_valid",  {7'd0, input_valid},   {7'd0, (m_q.size() != 8)});
    check("out_valid", {7'd0, output_valid},  {7'd0, (m_q.size() != 0)});
  endtask

  task automatic wr_byte(input logic [3:0] lo, input logic [3:0] hi);
    step(1'b1, 1'b0, lo);
    step(1'b1, 1'b0, hi);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_rd [12];
    logic [7:0] b;
    logic [7:0] prev;
    exp_rd = '{8'h1E, 8'h01, 8'h02, 8'h10, 8'h33, 8'h33, 8'h33, 8'h33,
               8'h20, 8'h00, 8'h00, 8'h01};

    // Reset held with random enables
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      input_enable  = 1'($urandom_range(0, 1));
      output_enable = 1'($urandom_range(0, 1));
      Data_In       = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check("rst_dout", Data_Out, 8'h00);
      check("rst_iv",   {7'd0, input_valid},  8'h01);
      check("rst_ov",   {7'd0, output_valid}, 8'h00);
    end
    @(negedge clk);
    input_enable  = 1'b0;
    output_enable = 1'b0;
    rst = 1'b0;
    model_reset();

    // Phase 0 after release: A then 5 makes 0x5A
    wr_byte(4'hA, 4'h5);
    step(1'b0, 1'b1, 4'h0);
    check("post_rst_byte", Data_Out, 8'h5A);

    // Fill and overflow
    wr_byte(4'hE, 4'h1);
    wr_byte(4'h1, 4'h0);
    wr_byte(4'h2, 4'h0);
    wr_byte(4'h0, 4'h1);
    for (int i = 0; i < 5; i++) wr_byte(4'h3, 4'h3);
    check("full_iv", {7'd0, input_valid},  8'h00);
    check("full_ov", {7'd0, output_valid}, 8'h01);

    // Drain interleaved with writes
    step(1'b0, 1'b1, 4'h0); check("drain0", Data_Out, exp_rd[0]);
    wr_byte(4'h0, 4'h2);
    step(1'b0, 1'b1, 4'h0); check("drain1", Data_Out, exp_rd[1]);
    wr_byte(4'h0, 4'h0);
    step(1'b0, 1'b1, 4'h0); check("drain2", Data_Out, exp_rd[2]);
    wr_byte(4'h0, 4'h0);
    step(1'b0, 1'b1, 4'h0); check("drain3", Data_Out, exp_rd[3]);
    wr_byte(4'h1, 4'h0);
    for (int i = 4; i < 12; i++) begin
      step(1'b0, 1'b1, 4'h0);
      check("drain", Data_Out, exp_rd[i]);
    end
    check("drained_ov", {7'd0, output_valid}, 8'h00);

    // Empty read leaves Data_Out alone
    step(1'b0, 1'b1, 4'h0);
    check("empty_rd_dout", Data_Out, 8'h01);
    check("empty_rd_ov",   {7'd0, output_valid}, 8'h00);

    // Wrap-around: write one byte, read the previous one in the same cycle
    prev = '0;
    for (int k = 0; k < 20; k++) begin
      b = 8'((k * 37 + 5) % 256);
      step(1'b1, 1'b0, b[3:0]);
      step(1'b1, 1'b1, b[7:4]);
      if (k > 0) check("wrap_rd", Data_Out, prev);
      prev = b;
    end
    step(1'b0, 1'b1, 4'h0);
    check("wrap_last", Data_Out, prev);
    check("wrap_empty", {7'd0, output_valid}, 8'h00);

    // Random traffic: write-heavy first half, read-heavy second half
    for (int i = 0; i < 100; i++) begin
      step(($urandom_range(0, 99) < ((i < 50) ? 85 : 25)),
           ($urandom_range(0, 99) < ((i < 50) ? 25 : 85)),
           4'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-cycle after a lone low nibble
    wr_byte(4'h7, 4'h8);
    step(1'b1, 1'b0, 4'hC);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dout", Data_Out, 8'h00);
    check("arst_iv",   {7'd0, input_valid},  8'h01);
    check("arst_ov",   {7'd0, output_valid}, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    wr_byte(4'h9, 4'h6);
    step(1'b0, 1'b1, 4'h0);
    check("arst_discard", Data_Out, 8'h69);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
